// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//   Round-robin arbiter that shares one 8:1 analog/digital mux channel among
//   eight requesters. It drives the mux select (A=SEL[2], B=SEL[1], C=SEL[0])
//   and the active-low enable directly. Between any two grants the mux is
//   disabled for at least one cycle (break-before-make), so the output never
//   switches sources while enabled.
//
//   Handshake: a source raises REQ[i] and holds it high for as long as it
//   needs the channel; GNT[i] (registered) tells it that it owns the channel.
//   Dropping REQ[i] while granted releases the channel at the next edge.
//
//   Optional feature: define MUX_ARB_TIMEOUT_EN to bound every grant to
//   MAX_HOLD cycles; a forced release pulses TIMEOUT for one cycle.
//   Without the macro there is no hold counter and TIMEOUT is tied low.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   REQ[7:0]    request per source
//   GNT[7:0]    one-hot grant, zero when idle
//   SEL[2:0]    index of granted source (holds last value while idle)
//   EN_L        mux enable, active low, low only while granted
//   BUSY        high while in GRANT
//   TIMEOUT     one-cycle pulse after a forced release
//   dbg_state_o current FSM state (1 = GRANT), for checkers
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] REQ,
  output logic [7:0] GNT,
  output logic [2:0] SEL,
  output logic       EN_L,
  output logic       BUSY,
  output logic       TIMEOUT,
  output logic       dbg_state_o
);

  // Reject an out-of-range hold limit at elaboration in every build.
  if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_max_hold
    $error("mux8_rr_arbiter: MAX_HOLD out of range for CNT_W");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       en_l_q, en_l_d;
  logic       busy_q, busy_d;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Winner search: first requesting index starting at ptr, wrapping mod 8.
  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    en_l_d  = en_l_q;
    busy_d  = busy_q;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef MUX_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (win_found) begin
          state_d = S_GRANT;
          sel_d   = win_idx;
          gnt_d   = 8'h01 << win_idx;
          en_l_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d = CNT_W'(1);
`endif
        end
      end
      S_GRANT: begin
        // Release (normal drop or forced) always lands in IDLE, which is
        // what guarantees the enable-off gap before the next grant.
        if (!REQ[sel_q]) begin
          state_d = S_IDLE;
          ptr_d   = sel_q + 3'd1;
          gnt_d   = 8'h00;
          en_l_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          state_d   = S_IDLE;
          ptr_d     = sel_q + 3'd1;
          gnt_d     = 8'h00;
          en_l_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      gnt_q   <= 8'h00;
      en_l_q  <= 1'b1;
      busy_q  <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      en_l_q  <= en_l_d;
      busy_q  <= busy_d;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign GNT         = gnt_q;
  assign SEL         = sel_q;
  assign EN_L        = en_l_q;
  assign BUSY        = busy_q;
  assign dbg_state_o = (state_q == S_GRANT);
`ifdef MUX_ARB_TIMEOUT_EN
  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule
